rtc_bus_cycle: RTL
==================

# rtc_bus_cycle

Bus-cycle sequencer for the RTC's multiplexed 8-bit address/data bus. It accepts one read or write request at a time and latches the request's address and write data. It sequences chip-select, address-strobe, read-strobe and write-strobe through fixed-length phases, and drives the select line of the downstream 2:1 bus multiplexer. That multiplexer places the address on the AD bus when select=1 and the write data when select=0. On reads the block captures the returned byte from the bus.

## Interface
- T_PHASE, 4: clock cycles per bus phase; legal range 1..255.
- clk  in  1  system clock, all state changes on rising edge.
- reset  in  1  asynchronous, active-low; forces the reset state immediately.
- start  in  1  request strobe; sampled only in IDLE.
- rw  in  1  1 = read, 0 = write; latched with start.
- addr  in  8  RTC register address; latched with start.
- wdata  in  8  write byte; latched with start.
- ad_in  in  8  bus value returned by the RTC during reads.
- addr_out  out  8  latched address; feeds the mux address input.
- data_out  out  8  latched write byte; feeds the mux data input.
- sel_addr  out  1  mux select: 1 = address, 0 = data.
- ad_oe  out  1  1 = FPGA drives the AD bus.
- cs_n, ad_n, rd_n, wr_n  out  1 each  active-low chip select, address strobe, read strobe, write strobe.
- rdata  out  8  last byte captured by a read.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, A_STB, A_HOLD, D_STB, D_HOLD, DONE.
- Phase counter: counts 0..T_PHASE-1 in each timed state. It advances to the next state when count = T_PHASE-1, then clears.
- Transition order: IDLE -(start)-> A_STB -> A_HOLD -> D_STB -> D_HOLD -> DONE -> IDLE. The DONE state lasts exactly 1 cycle.
- When start=1 in IDLE, the block latches rw, addr and wdata. addr_out and data_out update on the same edge. start in any other state is ignored, with no queuing.
- All outputs are registered and decoded from the next state, so they change only on clock edges and have no glitches.
- Output values per state (outputs not listed are high/inactive):
  - IDLE and DONE: cs_n=1, ad_n=1, rd_n=1, wr_n=1, sel_addr=1, ad_oe=0.
  - A_STB: cs_n=0, ad_n=0, wr_n=0, sel_addr=1, ad_oe=1.
  - A_HOLD: cs_n=0, sel_addr=1, ad_oe=1.
  - D_STB, write: cs_n=0, wr_n=0, sel_addr=0, ad_oe=1.
  - D_STB, read: cs_n=0, rd_n=0, sel_addr=0, ad_oe=0.
  - D_HOLD, write: sel_addr=0, ad_oe=1, so the data byte is held after the strobes rise.
  - D_HOLD, read: sel_addr=0, ad_oe=0.
- Read capture: rdata <= ad_in on the edge that ends D_STB, i.e. when count = T_PHASE-1 in D_STB.
- rdata holds its value until the next read capture. Writes never modify rdata.
- rd_n and wr_n are never low simultaneously. ad_oe is never 1 while rd_n = 0.

## Timing
- Reset values: state IDLE, count 0, addr_out 0x00, data_out 0x00, rdata 0x00, sel_addr 1, ad_oe 0, cs_n, ad_n, rd_n and wr_n all 1, busy 0, done 0.
- Latency: if start is sampled at edge k, A_STB begins after edge k, done is high for the cycle after edge k+4·T_PHASE, and busy falls with it one cycle later.
  - For T_PHASE=4, done is high during the 17th cycle after start.
- Back-to-back operation: the earliest next accepted start is one edge after DONE (in IDLE). A start that is held high continuously is re-accepted every 4·T_PHASE+2 cycles.
- T_PHASE=1: each phase lasts one cycle and the total latency is 5 cycles. The counter must stay at 0 in this case.
- Reset mid-transaction: all outputs return to reset values asynchronously. No done pulse is generated and the partial read is discarded, so rdata is 0x00.

## Test plan
- Reset, then idle: all outputs match the reset values; toggling start while reset=0 has no effect.
- Write, T_PHASE=4, addr=0x21, wdata=0x5A:
  - A_STB lasts 4 cycles with addr_out=0x21, sel_addr=1, ad_n=0, wr_n=0.
  - D_STB lasts 4 cycles with sel_addr=0, data_out=0x5A, wr_n=0.
  - done is high for exactly 1 cycle, 17 cycles after start; rdata is unchanged.
- Read, addr=0x42, ad_in=0x37 during D_STB: rd_n is low for 4 cycles with ad_oe=0; rdata=0x37 after the last D_STB edge; wr_n stays high throughout the data phase.
- start pulsed during A_HOLD and again during DONE: both are ignored, with only one done pulse; start held high gives a new transaction every 18 cycles.
- reset asserted in the middle of D_STB on a read: strobes are released immediately, rdata=0x00, no done pulse; a following normal read completes correctly.
- Build with T_PHASE=1: write and read each complete with done 5 cycles after start, and all strobe widths are 1 cycle.

Source files
------------

// File: rtl/rtc_bus_cycle_if.sv
// Request and bus-side signals of the RTC multiplexed-bus cycle sequencer.
// The master side issues requests and returns ad_in; the slave side is the sequencer.
interface rtc_bus_cycle_if;
  logic       start;
  logic       rw;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] ad_in;
  logic [7:0] addr_out;
  logic [7:0] data_out;
  logic [7:0] rdata;
  logic       sel_addr;
  logic       ad_oe;
  logic       cs_n;
  logic       ad_n;
  logic       rd_n;
  logic       wr_n;
  logic       busy;
  logic       done;

  modport master (
    output start, rw, addr, wdata, ad_in,
    input  addr_out, data_out, rdata, sel_addr, ad_oe, cs_n, ad_n, rd_n, wr_n, busy, done
  );

  modport slave (
    input  start, rw, addr, wdata, ad_in,
    output addr_out, data_out, rdata, sel_addr, ad_oe, cs_n, ad_n, rd_n, wr_n, busy, done
  );
endinterface

// File: rtl/rtc_bus_cycle.sv
// Bus-cycle sequencer for the RTC multiplexed AD bus: address phase, data phase, done pulse.
// All outputs are registered and decoded from the next state.
module rtc_bus_cycle #(
  parameter int T_PHASE = 4
) (
  input  logic               clk,
  input  logic               reset,
  rtc_bus_cycle_if.slave     bus
);
  typedef enum logic [2:0] {IDLE, A_STB, A_HOLD, D_STB, D_HOLD, DONE} state_t;

  state_t     state, nxt;
  logic [7:0] cnt;
  logic       rw_q;
  logic       last;

  assign last = (cnt == 8'(T_PHASE - 1));

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.start) nxt = A_STB;
      A_STB:   if (last) nxt = A_HOLD;
      A_HOLD:  if (last) nxt = D_STB;
      D_STB:   if (last) nxt = D_HOLD;
      D_HOLD:  if (last) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      rw_q         <= 1'b0;
      bus.addr_out <= 8'h00;
      bus.data_out <= 8'h00;
      bus.rdata    <= 8'h00;
      bus.sel_addr <= 1'b1;
      bus.ad_oe    <= 1'b0;
      bus.cs_n     <= 1'b1;
      bus.ad_n     <= 1'b1;
      bus.rd_n     <= 1'b1;
      bus.wr_n     <= 1'b1;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      state <= nxt;
      // Counter only runs inside the four timed phases and wraps on the last cycle.
      if ((state inside {A_STB, A_HOLD, D_STB, D_HOLD}) && !last) cnt <= cnt + 8'd1;
      else                                                         cnt <= 8'd0;

      if (state == IDLE && bus.start) begin
        rw_q         <= bus.rw;
        bus.addr_out <= bus.addr;
        bus.data_out <= bus.wdata;
      end
      if (state == D_STB && last && rw_q) bus.rdata <= bus.ad_in;

      // rw_q is already settled whenever nxt reaches a data phase.
      bus.cs_n     <= !(nxt inside {A_STB, A_HOLD, D_STB});
      bus.ad_n     <= (nxt != A_STB);
      bus.rd_n     <= !(nxt == D_STB && rw_q);
      bus.wr_n     <= !(nxt == A_STB || (nxt == D_STB && !rw_q));
      bus.sel_addr <= !(nxt inside {D_STB, D_HOLD});
      bus.ad_oe    <= (nxt inside {A_STB, A_HOLD}) || ((nxt inside {D_STB, D_HOLD}) && !rw_q);
      bus.busy     <= (nxt != IDLE);
      bus.done     <= (nxt == DONE);
    end
  end
endmodule
